// File: rtl/scariv_lsu_replay_selq.sv
// Age-matrix LSU replay queue: replays the oldest entry whose hazard has resolved; flushes free entries in place.
// Optional macro SCARIV_REPLAY_TIMEOUT_EN adds a per-entry watchdog that forces a starved entry ready.
module scariv_lsu_replay_selq #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 64,
    parameter int HAZ_IDX_W = 8,
    parameter int CMT_ID_W  = 6,
    parameter int GRP_W     = 4,
    parameter int TIMEOUT_W = 6
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_push_valid,
    input  logic [CMT_ID_W-1:0]          i_push_cmt_id,
    input  logic [GRP_W-1:0]             i_push_grp_id,
    input  logic [2:0]                   i_push_haz_typ,
    input  logic [HAZ_IDX_W-1:0]         i_push_haz_idx,
    input  logic [PAYLOAD_W-1:0]         i_push_payload,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_rep_valid,
    input  logic                         i_rep_ready,
    output logic [CMT_ID_W-1:0]          o_rep_cmt_id,
    output logic [GRP_W-1:0]             o_rep_grp_id,
    output logic [PAYLOAD_W-1:0]         o_rep_payload,
    input  logic                         i_flush_all,
    input  logic                         i_br_valid,
    input  logic                         i_br_mispredict,
    input  logic [CMT_ID_W-1:0]          i_br_cmt_id,
    input  logic [GRP_W-1:0]             i_br_grp_id,
    input  logic [CMT_ID_W-1:0]          i_rob_cmt_id,
    input  logic [GRP_W-1:0]             i_rob_done_grp,
    input  logic [HAZ_IDX_W-1:0]         i_stq_resolve_idx,
    input  logic                         i_missu_resolve_valid,
    input  logic [HAZ_IDX_W-1:0]         i_missu_resolve_oh,
    input  logic [HAZ_IDX_W-1:0]         i_missu_entry_valids,
    input  logic                         i_missu_full,
    input  logic                         i_missu_empty,
    input  logic                         i_st_buffer_empty
);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [2:0] HAZ_STQ_NONFWD     = 3'd0;
    localparam logic [2:0] HAZ_RMW_ORDER      = 3'd1;
    localparam logic [2:0] HAZ_L1D_CONFLICT   = 3'd2;
    localparam logic [2:0] HAZ_MISSU_FULL     = 3'd3;
    localparam logic [2:0] HAZ_MISSU_ASSIGNED = 3'd4;
    localparam logic [2:0] HAZ_VSTQ_HAZ       = 3'd5;

    if (DEPTH < 2 || TIMEOUT_W < 1) begin : g_param_chk
        $error("scariv_lsu_replay_selq: DEPTH must be >= 2 and TIMEOUT_W >= 1");
    end

    logic [DEPTH-1:0]     valid_reg;
    logic [DEPTH-1:0]     resolved_reg;
    logic [DEPTH-1:0]     age_reg [DEPTH];   // age_reg[i][j]: entry i is older than entry j
    logic                 full_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CMT_ID_W-1:0]  cmt_id_reg  [DEPTH];
    logic [GRP_W-1:0]     grp_id_reg  [DEPTH];
    logic [2:0]           haz_typ_reg [DEPTH];
    logic [HAZ_IDX_W-1:0] haz_idx_reg [DEPTH];
    logic [PAYLOAD_W-1:0] payload_reg [DEPTH];

    logic                 push_fire;
    logic                 rep_valid;
    logic [DEPTH-1:0]     push_oh;
    logic [DEPTH-1:0]     push_we;
    logic [DEPTH-1:0]     resolve_now;
    logic [DEPTH-1:0]     timeout;
    logic [DEPTH-1:0]     ready;
    logic [DEPTH-1:0]     sel_oh;
    logic [DEPTH-1:0]     pop_oh;
    logic [DEPTH-1:0]     flush_oh;
    logic [DEPTH-1:0]     valid_next;
    logic [CNT_W-1:0]     count_next;

    // Push is gated by the registered full flag, so a slot freed this cycle is not reused until the next.
    assign push_fire = i_push_valid & ~full_reg;

    always_comb begin
        push_oh = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                push_oh    = '0;
                push_oh[i] = 1'b1;
            end
        end
    end

    assign push_we = push_oh & {DEPTH{push_fire}};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [GRP_W-1:0] grp_m1;
        logic [DEPTH-1:0] older_col;
        logic             oldest;
        logic             cmt_gt;
        logic             cmt_wrap;
        logic             younger;
        logic             res_cond;

        assign grp_m1 = grp_id_reg[gi] - GRP_W'(1);
        assign oldest = (cmt_id_reg[gi] == i_rob_cmt_id) &&
                        ((i_rob_done_grp & grp_m1) == grp_m1);

        always_comb begin
            res_cond = 1'b0;
            case (haz_typ_reg[gi])
                HAZ_STQ_NONFWD:     res_cond = (haz_idx_reg[gi] & ~i_stq_resolve_idx) == '0;
                HAZ_RMW_ORDER:      res_cond = oldest & i_st_buffer_empty & i_missu_empty;
                HAZ_L1D_CONFLICT:   res_cond = 1'b1;
                HAZ_MISSU_FULL:     res_cond = ~i_missu_full;
                HAZ_MISSU_ASSIGNED: res_cond = (i_missu_resolve_valid && (i_missu_resolve_oh == haz_idx_reg[gi])) ||
                                               ((haz_idx_reg[gi] & i_missu_entry_valids) == '0);
                HAZ_VSTQ_HAZ:       res_cond = oldest;
                default:            res_cond = 1'b0;
            endcase
        end
        assign resolve_now[gi] = res_cond;

        // Wrap bit flips the sense of the low-bit comparison.
        assign cmt_gt   = cmt_id_reg[gi][CMT_ID_W-2:0] > i_br_cmt_id[CMT_ID_W-2:0];
        assign cmt_wrap = cmt_id_reg[gi][CMT_ID_W-1] != i_br_cmt_id[CMT_ID_W-1];
        assign younger  = (cmt_gt ^ cmt_wrap) ||
                          ((cmt_id_reg[gi] == i_br_cmt_id) && (grp_id_reg[gi] > i_br_grp_id));

        assign flush_oh[gi] = valid_reg[gi] & (i_flush_all | (i_br_valid & i_br_mispredict & younger));
        assign ready[gi]    = valid_reg[gi] & (resolved_reg[gi] | timeout[gi]);

        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
            assign older_col[gj] = age_reg[gj][gi];
        end
        assign sel_oh[gi] = ready[gi] & ~|(ready & older_col);
    end

    assign rep_valid = |ready;
    assign pop_oh    = sel_oh & {DEPTH{rep_valid & i_rep_ready}};

    always_comb begin
        o_rep_cmt_id  = '0;
        o_rep_grp_id  = '0;
        o_rep_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                o_rep_cmt_id  = o_rep_cmt_id  | cmt_id_reg[i];
                o_rep_grp_id  = o_rep_grp_id  | grp_id_reg[i];
                o_rep_payload = o_rep_payload | payload_reg[i];
            end
        end
    end

    assign valid_next = (valid_reg & ~pop_oh & ~flush_oh) | push_we;

    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CNT_W'(valid_next[i]);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_reg    <= '0;
            resolved_reg <= '0;
            full_reg     <= 1'b0;
            count_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_reg[i] <= '0;
            end
        end else begin
            valid_reg    <= valid_next;
            count_reg    <= count_next;
            full_reg     <= (count_next == CNT_W'(DEPTH));
            resolved_reg <= (resolved_reg | (valid_reg & resolve_now)) & ~push_we;
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (push_we[j]) begin
                        age_reg[i][j] <= valid_reg[i];
                    end else if (push_we[i] || pop_oh[j]) begin
                        age_reg[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Entry contents only matter while valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_we[i]) begin
                cmt_id_reg[i]  <= i_push_cmt_id;
                grp_id_reg[i]  <= i_push_grp_id;
                haz_typ_reg[i] <= i_push_haz_typ;
                haz_idx_reg[i] <= i_push_haz_idx;
                payload_reg[i] <= i_push_payload;
            end
        end
    end

`ifdef SCARIV_REPLAY_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_reg [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tmo
        assign timeout[gi] = &tmo_cnt_reg[gi];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tmo_cnt_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_we[i]) begin
                    tmo_cnt_reg[i] <= '0;
                end else if (valid_reg[i] && !resolved_reg[i] && !timeout[i]) begin
                    tmo_cnt_reg[i] <= tmo_cnt_reg[i] + TIMEOUT_W'(1);
                end
            end
        end
    end
`else
    assign timeout = '0;
`endif

    assign o_full      = full_reg;
    assign o_count     = count_reg;
    assign o_rep_valid = rep_valid;

endmodule

// File: tb/tb_scariv_lsu_replay_selq.sv
// Bench for scariv_lsu_replay_selq: directed scenarios plus random traffic against an age-ordered list model.
module tb_scariv_lsu_replay_selq;
    localparam int DEPTH     = 8;
    localparam int PAYLOAD_W = 64;
    localparam int HAZ_IDX_W = 8;
    localparam int CMT_ID_W  = 6;
    localparam int GRP_W     = 4;
    localparam int TIMEOUT_W = 3;
    localparam int TMO_MAX   = (1 << TIMEOUT_W) - 1;
`ifdef SCARIV_REPLAY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 push_valid;
    logic [CMT_ID_W-1:0]  push_cmt;
    logic [GRP_W-1:0]     push_grp;
    logic [2:0]           push_typ;
    logic [HAZ_IDX_W-1:0] push_idx;
    logic [PAYLOAD_W-1:0] push_payload;
    logic                 full;
    logic [3:0]           count;
    logic                 rep_valid;
    logic                 rep_ready;
    logic [CMT_ID_W-1:0]  rep_cmt;
    logic [GRP_W-1:0]     rep_grp;
    logic [PAYLOAD_W-1:0] rep_payload;
    logic                 flush_all, br_valid, br_mispredict;
    logic [CMT_ID_W-1:0]  br_cmt, rob_cmt;
    logic [GRP_W-1:0]     br_grp, rob_done_grp;
    logic [HAZ_IDX_W-1:0] stq_res, missu_res_oh, missu_valids;
    logic                 missu_res_v, missu_full, missu_empty, stbuf_empty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CMT_ID_W-1:0]  cmt;
        logic [GRP_W-1:0]     grp;
        logic [2:0]           typ;
        logic [HAZ_IDX_W-1:0] idx;
        logic [PAYLOAD_W-1:0] payload;
        bit                   resolved;
        int                   tmo;
    } ent_t;

    ent_t q[$];   // valid entries, oldest first

    always #5 clk = ~clk;

    scariv_lsu_replay_selq #(
        .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .HAZ_IDX_W(HAZ_IDX_W),
        .CMT_ID_W(CMT_ID_W), .GRP_W(GRP_W), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_push_valid(push_valid), .i_push_cmt_id(push_cmt), .i_push_grp_id(push_grp),
        .i_push_haz_typ(push_typ), .i_push_haz_idx(push_idx), .i_push_payload(push_payload),
        .o_full(full), .o_count(count),
        .o_rep_valid(rep_valid), .i_rep_ready(rep_ready),
        .o_rep_cmt_id(rep_cmt), .o_rep_grp_id(rep_grp), .o_rep_payload(rep_payload),
        .i_flush_all(flush_all), .i_br_valid(br_valid), .i_br_mispredict(br_mispredict),
        .i_br_cmt_id(br_cmt), .i_br_grp_id(br_grp),
        .i_rob_cmt_id(rob_cmt), .i_rob_done_grp(rob_done_grp),
        .i_stq_resolve_idx(stq_res),
        .i_missu_resolve_valid(missu_res_v), .i_missu_resolve_oh(missu_res_oh),
        .i_missu_entry_valids(missu_valids),
        .i_missu_full(missu_full), .i_missu_empty(missu_empty), .i_st_buffer_empty(stbuf_empty)
    );

    function automatic bit m_cond(ent_t e);
        logic [GRP_W-1:0] gm1;
        bit oldest;
        gm1 = e.grp - 1'b1;
        oldest = (e.cmt == rob_cmt) && ((rob_done_grp & gm1) == gm1);
        case (e.typ)
            3'd0:    return (e.idx & ~stq_res) == 0;
            3'd1:    return oldest && stbuf_empty && missu_empty;
            3'd2:    return 1'b1;
            3'd3:    return !missu_full;
            3'd4:    return (missu_res_v && missu_res_oh == e.idx) || ((e.idx & missu_valids) == 0);
            3'd5:    return oldest;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_younger(ent_t e);
        bit gt, wrap;
        gt   = e.cmt[CMT_ID_W-2:0] > br_cmt[CMT_ID_W-2:0];
        wrap = e.cmt[CMT_ID_W-1] != br_cmt[CMT_ID_W-1];
        return (gt ^ wrap) || (e.cmt == br_cmt && e.grp > br_grp);
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].resolved || (TMO_EN && q[i].tmo == TMO_MAX)) return i;
        end
        return -1;
    endfunction

    // Advance model by one clock using the inputs currently driven, then wait for the DUT edge.
    task automatic tick();
        int   s;
        bit   pop, was_full;
        ent_t nq[$];
        ent_t n;
        s        = m_sel();
        pop      = (s >= 0) && rep_ready;
        was_full = (q.size() == DEPTH);
        for (int i = 0; i < q.size(); i++) begin
            ent_t e;
            e = q[i];
            if (pop && i == s) continue;
            if (flush_all || (br_valid && br_mispredict && m_younger(e))) continue;
            if (!e.resolved && e.tmo < TMO_MAX) e.tmo++;
            if (m_cond(e)) e.resolved = 1'b1;
            nq.push_back(e);
        end
        if (push_valid && !was_full) begin
            n.cmt = push_cmt; n.grp = push_grp; n.typ = push_typ; n.idx = push_idx;
            n.payload = push_payload; n.resolved = 1'b0; n.tmo = 0;
            nq.push_back(n);
        end
        q = nq;
        @(negedge clk);
    endtask

    task automatic set_idle();
        push_valid = 0; push_cmt = 0; push_grp = 4'b0001; push_typ = 0; push_idx = 0; push_payload = 0;
        rep_ready = 0; flush_all = 0; br_valid = 0; br_mispredict = 0; br_cmt = 0; br_grp = 0;
        rob_cmt = 6'h3F; rob_done_grp = 0; stq_res = 0; missu_res_v = 0; missu_res_oh = 0;
        missu_valids = 8'hFF; missu_full = 0; missu_empty = 0; stbuf_empty = 0;
    endtask

    task automatic set_push(input logic [2:0] typ, input logic [7:0] idx, input logic [5:0] cmt,
                            input logic [63:0] pl);
        push_valid = 1; push_typ = typ; push_idx = idx; push_cmt = cmt; push_grp = 4'b0001; push_payload = pl;
    endtask

    task automatic clear_all();
        set_idle();
        flush_all = 1;
        tick();
        flush_all = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        repeat (3) @(negedge clk);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got=%0d exp=0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got=%0b exp=0", full); end
        total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL reset_rep_valid: got=%0b exp=0", rep_valid); end
        rst_n = 1;
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL post_reset_count: got=%0d exp=0", count); end
    endtask

    task automatic test_l1d_latency();
        clear_all();
        rep_ready = 1;
        set_push(3'd2, 8'h00, 6'd1, 64'hDEAD_BEEF_0123_4567);
        tick();
        push_valid = 0;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL l1d_count_t1: got=%0d exp=1", count); end
        total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL l1d_valid_t1: got=%0b exp=0", rep_valid); end
        tick();
        total++; if (rep_valid !== 1'b1) begin bad++; $display("FAIL l1d_valid_t2: got=%0b exp=1", rep_valid); end
        total++; if (rep_payload !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL l1d_payload: got=%h exp=deadbeef01234567", rep_payload); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL l1d_count_t3: got=%0d exp=0", count); end
        total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL l1d_valid_t3: got=%0b exp=0", rep_valid); end
    endtask

    task automatic test_age_bypass();
        clear_all();
        rep_ready = 1;
        set_push(3'd4, 8'h01, 6'd2, 64'hA);
        tick();
        set_push(3'd2, 8'h00, 6'd3, 64'hB);
        tick();
        push_valid = 0;
        total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL bypass_early: got=%0b exp=0", rep_valid); end
        tick();
        total++; if (rep_valid !== 1'b1 || rep_cmt !== 6'd3) begin bad++; $display("FAIL bypass_b_first: valid=%0b cmt=%0d exp valid=1 cmt=3", rep_valid, rep_cmt); end
        tick();
        total++; if (rep_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("FAIL bypass_a_blocked: valid=%0b count=%0d exp valid=0 count=1", rep_valid, count); end
        missu_res_v = 1; missu_res_oh = 8'h01;
        tick();
        missu_res_v = 0; missu_res_oh = 0;
        total++; if (rep_valid !== 1'b1 || rep_cmt !== 6'd2) begin bad++; $display("FAIL bypass_a_replay: valid=%0b cmt=%0d exp valid=1 cmt=2", rep_valid, rep_cmt); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL bypass_drain: got=%0d exp=0", count); end
    endtask

    task automatic test_stq_order();
        clear_all();
        rep_ready = 1;
        set_push(3'd0, 8'h04, 6'd4, 64'h44);
        tick();
        set_push(3'd0, 8'h04, 6'd5, 64'h55);
        tick();
        push_valid = 0;
        tick();
        total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL stq_unresolved: got=%0b exp=0", rep_valid); end
        stq_res = 8'h04;
        tick();
        stq_res = 0;
        total++; if (rep_valid !== 1'b1 || rep_cmt !== 6'd4) begin bad++; $display("FAIL stq_older_first: valid=%0b cmt=%0d exp valid=1 cmt=4", rep_valid, rep_cmt); end
        tick();
        total++; if (rep_valid !== 1'b1 || rep_cmt !== 6'd5) begin bad++; $display("FAIL stq_younger_next: valid=%0b cmt=%0d exp valid=1 cmt=5", rep_valid, rep_cmt); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL stq_drain: got=%0d exp=0", count); end
    endtask

    task automatic test_full();
        clear_all();
        for (int i = 0; i < DEPTH; i++) begin
            set_push(3'd2, 8'h00, 6'(i), 64'(i));
            tick();
        end
        total++; if (full !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL full_set: full=%0b count=%0d exp full=1 count=8", full, count); end
        set_push(3'd2, 8'h00, 6'd40, 64'h99);
        tick();
        push_valid = 0;
        total++; if (full !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL full_drop: full=%0b count=%0d exp full=1 count=8", full, count); end
        total++; if (rep_cmt !== 6'd0) begin bad++; $display("FAIL full_oldest: got=%0d exp=0", rep_cmt); end
        rep_ready = 1;
        tick();
        rep_ready = 0;
        total++; if (full !== 1'b0 || count !== 4'd7) begin bad++; $display("FAIL full_pop: full=%0b count=%0d exp full=0 count=7", full, count); end
    endtask

    task automatic test_branch_flush();
        clear_all();
        missu_full = 1;
        set_push(3'd3, 8'h00, 6'd5, 64'h5);
        tick();
        set_push(3'd3, 8'h00, 6'd9, 64'h9);
        tick();
        push_valid = 0;
        total++; if (count !== 4'd2) begin bad++; $display("FAIL br_count_before: got=%0d exp=2", count); end
        br_valid = 1; br_mispredict = 1; br_cmt = 6'd7; br_grp = 4'b0001;
        tick();
        br_valid = 0; br_mispredict = 0;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL br_count_after: got=%0d exp=1", count); end
        missu_full = 0;
        tick();
        total++; if (rep_valid !== 1'b1 || rep_cmt !== 6'd5) begin bad++; $display("FAIL br_survivor: valid=%0b cmt=%0d exp valid=1 cmt=5", rep_valid, rep_cmt); end
        flush_all = 1;
        tick();
        flush_all = 0;
        total++; if (count !== 4'd0 || rep_valid !== 1'b0) begin bad++; $display("FAIL flush_all: count=%0d valid=%0b exp count=0 valid=0", count, rep_valid); end
    endtask

    task automatic test_timeout();
        int first;
        int exp_first;
        first = -1;
        exp_first = TMO_EN ? (1 << TIMEOUT_W) : -1;
        clear_all();
        missu_full = 1; rep_ready = 1;
        set_push(3'd3, 8'h00, 6'd12, 64'h7);
        tick();
        push_valid = 0;
        for (int c = 1; c <= 20 && first < 0; c++) begin
            if (rep_valid) first = c;
            else tick();
        end
        total++; if (first !== exp_first) begin bad++; $display("FAIL timeout_cycle: got=%0d exp=%0d", first, exp_first); end
        clear_all();
        missu_full = 1; rep_ready = 1;
        set_push(3'd3, 8'h00, 6'd13, 64'h8);
        tick();
        push_valid = 0;
        tick();
        total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL missu_full_hold: got=%0b exp=0", rep_valid); end
        missu_full = 0;
        tick();
        total++; if (rep_valid !== 1'b1 || rep_payload !== 64'h8) begin bad++; $display("FAIL missu_full_release: valid=%0b payload=%h exp valid=1 payload=8", rep_valid, rep_payload); end
    endtask

    task automatic test_random();
        int s;
        clear_all();
        for (int n = 0; n < 3000; n++) begin
            push_valid    = ($urandom_range(0, 9) < 6);
            push_typ      = 3'($urandom_range(0, 5));
            push_idx      = 8'(1 << $urandom_range(0, 7));
            push_cmt      = 6'($urandom_range(0, 63));
            push_grp      = 4'(1 << $urandom_range(0, 3));
            push_payload  = {$urandom(), $urandom()};
            rep_ready     = ($urandom_range(0, 9) < 7);
            flush_all     = ($urandom_range(0, 99) == 0);
            br_valid      = ($urandom_range(0, 29) == 0);
            br_mispredict = $urandom_range(0, 1);
            br_cmt        = 6'($urandom_range(0, 63));
            br_grp        = 4'(1 << $urandom_range(0, 3));
            rob_cmt       = (q.size() > 0 && $urandom_range(0, 1)) ? q[0].cmt : 6'($urandom_range(0, 63));
            rob_done_grp  = 4'($urandom_range(0, 15));
            stq_res       = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            missu_res_v   = ($urandom_range(0, 3) == 0);
            missu_res_oh  = 8'(1 << $urandom_range(0, 7));
            missu_valids  = 8'($urandom_range(0, 255) | $urandom_range(0, 255));
            missu_full    = $urandom_range(0, 1);
            missu_empty   = $urandom_range(0, 1);
            stbuf_empty   = $urandom_range(0, 1);
            tick();
            s = m_sel();
            total++; if (rep_valid !== (s >= 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d: got=%0b exp=%0b", n, rep_valid, (s >= 0)); end
            total++; if (count !== 4'(q.size())) begin bad++; $display("FAIL rnd_count cyc=%0d: got=%0d exp=%0d", n, count, q.size()); end
            total++; if (full !== (q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full cyc=%0d: got=%0b exp=%0b", n, full, (q.size() == DEPTH)); end
            if (s >= 0) begin
                total++;
                if (rep_cmt !== q[s].cmt || rep_grp !== q[s].grp || rep_payload !== q[s].payload) begin
                    bad++;
                    $display("FAIL rnd_sel cyc=%0d: got cmt=%0d grp=%h pl=%h exp cmt=%0d grp=%h pl=%h",
                             n, rep_cmt, rep_grp, rep_payload, q[s].cmt, q[s].grp, q[s].payload);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_l1d_latency();
        test_age_bypass();
        test_stq_order();
        test_full();
        test_branch_flush();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
